mem_stage: RTL and testbench

- MEMORY (MEM) stage logic between the EX/MEM latch and the MEM/WB latch.
- Owns the word-addressed data memory and performs loads and stores with a configurable multi-cycle access latency.
- Raises `stall` so the upstream pipeline holds while an access is in flight.
- Presents control_wb, read data, ALU result and destination register to the MEM/WB latch; outputs are a bubble while stalled.

---
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage: word data memory with MEM_LATENCY-cycle accesses (stall held for the access, then one DONE cycle); non-memory ops pass through in zero cycles.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses set sticky misalign_err, stores are dropped and loads return zero.
module mem_stage #(
    parameter int ADDR_W      = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  control_wb_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] Write_data_in,
    input  logic [4:0]  Write_reg_in,
    output logic        stall,
    output logic [1:0]  control_wb_out,
    output logic [31:0] Read_data_out,
    output logic [31:0] ALU_result_out,
    output logic [4:0]  Write_reg_out,
    output logic        misalign_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (MEM_LATENCY >= 2) ? 4'(MEM_LATENCY - 2) : 4'd0;

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("mem_stage: MEM_LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t              state, state_n;
    logic [3:0]          cnt, cnt_n;
    logic                enter_done;
    logic                req;
    logic                mis;
    logic [ADDR_W-1:0]   idx;
    logic [31:0]         rd_q;
    logic [31:0]         mem [DEPTH] = '{default: '0};

    assign req = mem_read | mem_write;
    assign idx = ALU_result_in[ADDR_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    assign mis = (ALU_result_in[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        enter_done     = 1'b0;
        stall          = 1'b0;
        control_wb_out = control_wb_in;
        case (state)
            IDLE: begin
                if (req) begin
                    stall          = 1'b1;
                    control_wb_out = 2'b00;
                    if (MEM_LATENCY == 1) begin
                        state_n    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                stall          = 1'b1;
                control_wb_out = 2'b00;
                if (cnt == 4'd0) begin
                    state_n    = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
                if (mis && mem_read) begin
                    control_wb_out = 2'b00;
                end
            end
            default: state_n = IDLE;
        endcase
        // Reset aborts any access immediately, including its stall.
        if (rst) begin
            stall          = 1'b0;
            control_wb_out = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Read data is captured entering DONE, so a combined read+write returns pre-store content.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= 32'd0;
        end else if (enter_done) begin
            rd_q <= mis ? 32'd0 : mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == DONE && mem_write && !mis) begin
            mem[idx] <= Write_data_in;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (enter_done && mis) begin
            err_q <= 1'b1;
        end
    end
    assign misalign_err = err_q;
`else
    assign misalign_err = 1'b0;
`endif

    assign Read_data_out  = rd_q;
    assign ALU_result_out = ALU_result_in;
    assign Write_reg_out  = Write_reg_in;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three instances (latency 2, 1, 3) driven by directed vectors and random traffic against a word-array memory model.
module tb_mem_stage;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [N];
    logic [1:0]  cwb_in    [N];
    logic        mem_read  [N];
    logic        mem_write [N];
    logic [31:0] alu_in    [N];
    logic [31:0] wd_in     [N];
    logic [4:0]  wr_in     [N];
    logic        stall     [N];
    logic [1:0]  cwb_out   [N];
    logic [31:0] rd_out    [N];
    logic [31:0] alu_out   [N];
    logic [4:0]  wr_out    [N];
    logic        err_out   [N];

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            mem_stage #(
                .ADDR_W(8),
                .MEM_LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 3))
            ) u_dut (
                .clk(clk),
                .rst(rst[g]),
                .control_wb_in(cwb_in[g]),
                .mem_read(mem_read[g]),
                .mem_write(mem_write[g]),
                .ALU_result_in(alu_in[g]),
                .Write_data_in(wd_in[g]),
                .Write_reg_in(wr_in[g]),
                .stall(stall[g]),
                .control_wb_out(cwb_out[g]),
                .Read_data_out(rd_out[g]),
                .ALU_result_out(alu_out[g]),
                .Write_reg_out(wr_out[g]),
                .misalign_err(err_out[g])
            );
        end
    endgenerate

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic [31:0] model_mem [N][256];
    logic [31:0] last_rd   [N];
    logic        exp_err   [N];
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          k;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  cwb;
        logic [4:0]  wreg;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; mem_read[k] = 1'b1; mem_write[k] = 1'b1; cwb_in[k] = 2'b11;
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("rst_stall", 32'(stall[k]), 32'd0);
            chk("rst_cwb", 32'(cwb_out[k]), 32'd0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b0; mem_read[k] = 1'b0; mem_write[k] = 1'b0;
            last_rd[k] = 32'd0; exp_err[k] = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("rst_rdata", rd_out[k], 32'd0);
            chk("rst_err", 32'(err_out[k]), 32'd0);
            chk("rst_idle_stall", 32'(stall[k]), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_check(input int k, input logic [31:0] addr, input logic [1:0] cwb,
                              input logic [4:0] wreg, input string name);
        mem_read[k] = 1'b0; mem_write[k] = 1'b0;
        alu_in[k] = addr; cwb_in[k] = cwb; wr_in[k] = wreg; wd_in[k] = $urandom;
        @(negedge clk);
        chk({name, "_stall"}, 32'(stall[k]), 32'd0);
        chk({name, "_cwb"}, 32'(cwb_out[k]), 32'(cwb));
        chk({name, "_alu"}, alu_out[k], addr);
        chk({name, "_wreg"}, 32'(wr_out[k]), 32'(wreg));
        chk({name, "_rdata"}, rd_out[k], last_rd[k]);
        chk({name, "_err"}, 32'(err_out[k]), 32'(exp_err[k]));
        @(posedge clk); #1;
    endtask

    // Starts in IDLE just after a rising edge; returns just after the edge that ends DONE.
    task automatic do_access(input int k, input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] cwb, input logic [4:0] wreg,
                             input logic [31:0] exp_tab, input bit use_tab, input string name);
        logic [7:0]  w;
        bit          mis;
        logic [31:0] er;
        logic [1:0]  ec;
        int          cyc;
        w   = addr[9:2];
        mis = ALIGN_CHK && (addr[1:0] != 2'b00);
        er  = use_tab ? exp_tab : (mis ? 32'd0 : model_mem[k][w]);
        ec  = (mis && rd) ? 2'b00 : cwb;
        mem_read[k] = rd; mem_write[k] = wr;
        alu_in[k] = addr; wd_in[k] = wdata; cwb_in[k] = cwb; wr_in[k] = wreg;
        cyc = 0;
        @(negedge clk);
        while (stall[k] && cyc < 40) begin
            chk({name, "_bubble"}, 32'(cwb_out[k]), 32'd0);
            cyc++;
            @(negedge clk);
        end
        chk({name, "_stall_cycles"}, 32'(cyc), 32'(lat_of(k)));
        if (mis) exp_err[k] = 1'b1;
        chk({name, "_rdata"}, rd_out[k], er);
        chk({name, "_cwb"}, 32'(cwb_out[k]), 32'(ec));
        chk({name, "_alu"}, alu_out[k], addr);
        chk({name, "_wreg"}, 32'(wr_out[k]), 32'(wreg));
        chk({name, "_err"}, 32'(err_out[k]), 32'(exp_err[k]));
        @(posedge clk); #1;
        mem_read[k] = 1'b0; mem_write[k] = 1'b0;
        if (wr && !mis) model_mem[k][w] = wdata;
        last_rd[k] = er;
    endtask

    task automatic abort_store(input int k, input logic [31:0] addr, input logic [31:0] data,
                               input int n, input string name);
        mem_read[k] = 1'b0; mem_write[k] = 1'b1;
        alu_in[k] = addr; wd_in[k] = data; cwb_in[k] = 2'b00; wr_in[k] = 5'd0;
        repeat (n) @(negedge clk);
        rst[k] = 1'b1;
        #1;
        chk({name, "_stall_in_rst"}, 32'(stall[k]), 32'd0);
        chk({name, "_cwb_in_rst"}, 32'(cwb_out[k]), 32'd0);
        @(posedge clk); #1;
        rst[k] = 1'b0; mem_write[k] = 1'b0;
        last_rd[k] = 32'd0; exp_err[k] = 1'b0;
        @(negedge clk);
        chk({name, "_stall_after"}, 32'(stall[k]), 32'd0);
        chk({name, "_rdata_after"}, rd_out[k], 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 2'b00, 5'd1, 32'h0};
        vecs[1] = '{0, 1'b1, 1'b0, 32'h10,  32'h0,        2'b11, 5'd2, 32'hDEADBEEF};
        vecs[2] = '{1, 1'b0, 1'b1, 32'h0,   32'h55,       2'b00, 5'd3, 32'h0};
        vecs[3] = '{1, 1'b1, 1'b0, 32'h400, 32'h0,        2'b11, 5'd4, 32'h55};
        vecs[4] = '{0, 1'b0, 1'b1, 32'h20,  32'h11,       2'b00, 5'd5, 32'h0};
        vecs[5] = '{0, 1'b1, 1'b1, 32'h20,  32'h22,       2'b11, 5'd6, 32'h11};
        vecs[6] = '{0, 1'b1, 1'b0, 32'h20,  32'h0,        2'b11, 5'd7, 32'h22};
        vecs[7] = '{2, 1'b0, 1'b1, 32'h3FC, 32'h12345678, 2'b00, 5'd8, 32'h0};
        vecs[8] = '{2, 1'b1, 1'b0, 32'h7FC, 32'h0,        2'b11, 5'd9, 32'h12345678};
        vecs[9] = '{2, 1'b1, 1'b0, 32'h3C,  32'h0,        2'b10, 5'd10, 32'h0};

        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 256; i++) model_mem[k][i] = 32'd0;
            rst[k] = 1'b1; mem_read[k] = 1'b0; mem_write[k] = 1'b0;
            cwb_in[k] = 2'b00; alu_in[k] = 32'd0; wd_in[k] = 32'd0; wr_in[k] = 5'd0;
            last_rd[k] = 32'd0; exp_err[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 3; i++) idle_check(0, 32'h1234, 2'b10, 5'd9, "idle_pass");
        idle_check(1, 32'hCAFE_0004, 2'b01, 5'd31, "idle_pass_b");

        for (int i = 0; i < 10; i++)
            do_access(vecs[i].k, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                      vecs[i].cwb, vecs[i].wreg, vecs[i].exp_rd, 1'b1, $sformatf("vec%0d", i));

        abort_store(0, 32'h30, 32'hAAAA, 3, "abort_done");
        do_access(0, 1'b1, 1'b0, 32'h30, 32'h0, 2'b11, 5'd11, 32'h0, 1'b1, "abort_done_load");
        abort_store(2, 32'h44, 32'hBBBB, 2, "abort_wait");
        do_access(2, 1'b1, 1'b0, 32'h44, 32'h0, 2'b11, 5'd12, 32'h0, 1'b1, "abort_wait_load");

`ifdef MEM_ALIGN_CHECK_EN
        do_access(0, 1'b0, 1'b1, 32'h42, 32'hBAD0BAD0, 2'b00, 5'd13, 32'h0, 1'b1, "mis_store");
        do_access(0, 1'b1, 1'b0, 32'h40, 32'h0, 2'b11, 5'd14, 32'h0, 1'b0, "mis_after_load");
        idle_check(0, 32'h0, 2'b10, 5'd1, "mis_sticky");
        do_access(1, 1'b1, 1'b0, 32'h1, 32'h0, 2'b11, 5'd15, 32'h0, 1'b1, "mis_load");
        do_reset();
`endif

        for (int it = 0; it < 300; it++) begin
            int          k;
            int          op;
            logic [31:0] addr;
            k    = $urandom_range(0, N - 1);
            op   = $urandom_range(0, 3);
            addr = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom);
            if (op == 0)
                idle_check(k, addr, 2'($urandom), 5'($urandom), "rnd_idle");
            else
                do_access(k, op[0], op[1], addr, $urandom, 2'($urandom), 5'($urandom),
                          32'h0, 1'b0, "rnd_acc");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
